// File: rtl/agc_stage_pkg.sv
// Shared definitions for the stage sequencer: ring length, stage codes and
// the divide-sequence successor function.
package agc_stage_pkg;

    localparam int NTP_DEF = 12;

    localparam logic [2:0] STG_DV0 = 3'd0;
    localparam logic [2:0] STG_DV1 = 3'd1;
    localparam logic [2:0] STG_DV3 = 3'd3;
    localparam logic [2:0] STG_DV7 = 3'd7;
    localparam logic [2:0] STG_DV6 = 3'd6;
    localparam logic [2:0] STG_DV4 = 3'd4;

    // Result of one divide step: legal=0 means the current code is not part
    // of the divide chain and the sequencer must drop out of divide.
    typedef struct packed {
        logic       legal;
        logic [2:0] code;
    } dv_step_t;

    // Successor along the divide chain 0->1->3->7->6->4. The final code (4)
    // is handled by the caller; anything off the chain is flagged illegal.
    function automatic dv_step_t next_dv_stage(input logic [2:0] cur);
        dv_step_t r;
        r.legal = 1'b1;
        r.code  = STG_DV0;
        case (cur)
            STG_DV0: r.code = STG_DV1;
            STG_DV1: r.code = STG_DV3;
            STG_DV3: r.code = STG_DV7;
            STG_DV7: r.code = STG_DV6;
            STG_DV6: r.code = STG_DV4;
            default: begin
                r.legal = 1'b0;
                r.code  = STG_DV0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tp_ring.sv
// Timepulse ring: counts 1..NTP, holds at NTP while mstp is high and
// restarts at 1 on gojam.
module tp_ring
    import agc_stage_pkg::*;
#(
    parameter int NTP = NTP_DEF,
    parameter int TPW = $clog2(NTP + 1)
) (
    input  logic           clock,
    input  logic           rst_n,
    input  logic           gojam,
    input  logic           mstp,
    output logic [TPW-1:0] tp,
    output logic           t12
);

    logic [TPW-1:0] tp_r;

    // Ring position register with restart, monitor-stop hold and wrap.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tp_r <= TPW'(1);
        end else if (gojam) begin
            tp_r <= TPW'(1);
        end else if (tp_r == TPW'(NTP)) begin
            if (mstp) begin
                tp_r <= tp_r;
            end else begin
                tp_r <= TPW'(1);
            end
        end else begin
            tp_r <= tp_r + TPW'(1);
        end
    end

    assign tp  = tp_r;
    assign t12 = (tp_r == TPW'(NTP));

endmodule

// File: rtl/stage_seq.sv
// Stage-sequencing controller: timepulse ring, stage register STG1..STG3,
// the six-MCT divide sequence and the stage/divide decodes.
module stage_seq
    import agc_stage_pkg::*;
#(
    parameter int         NTP    = NTP_DEF,
    parameter logic [2:0] DVLAST = 3'b100
) (
    input  logic           CLOCK,
    input  logic           rst,
    input  logic           GOJAM,
    input  logic           MSTP,
    input  logic           DVST,
    input  logic           RSTSTG,
    input  logic           ST1,
    input  logic           ST2,
    output logic [NTP-1:0] T_,
    output logic [2:0]     STG,
    output logic           DIVSTG,
    output logic           DV0,
    output logic           DV1,
    output logic           DV4,
    output logic           DV376,
    output logic           DV1376,
    output logic           DV3764,
    output logic           ST0_,
    output logic           ST1_,
    output logic           ST3_,
    output logic           DVDONE
);

    localparam int TPW = $clog2(NTP + 1);

    logic [TPW-1:0] tp_s;
    logic           t12_s;
    logic           adv_s;
    logic [2:0]     stg_r;
    logic [2:0]     stg_nxt_s;
    logic           div_r;
    logic           div_nxt_s;
    dv_step_t       step_s;
    logic [NTP-1:0] t_s;

    tp_ring #(
        .NTP (NTP),
        .TPW (TPW)
    ) u_ring (
        .clock (CLOCK),
        .rst_n (rst),
        .gojam (GOJAM),
        .mstp  (MSTP),
        .tp    (tp_s),
        .t12   (t12_s)
    );

    // Stage only moves on the edge that actually leaves T12.
    assign adv_s  = t12_s & ~MSTP;
    assign step_s = next_dv_stage(stg_r);

    // Stage and divide-active registers.
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            stg_r <= 3'd0;
            div_r <= 1'b0;
        end else begin
            stg_r <= stg_nxt_s;
            div_r <= div_nxt_s;
        end
    end

    // Next stage: restart, stage reset, divide stepping, divide entry, normal.
    always_comb begin
        stg_nxt_s = stg_r;
        div_nxt_s = div_r;
        if (GOJAM) begin
            stg_nxt_s = 3'd0;
            div_nxt_s = 1'b0;
        end else if (adv_s) begin
            if (RSTSTG) begin
                stg_nxt_s = 3'd0;
                div_nxt_s = 1'b0;
            end else if (div_r) begin
                if (stg_r == DVLAST) begin
                    stg_nxt_s = {1'b0, ST2, ST1};
                    div_nxt_s = 1'b0;
                end else if (step_s.legal) begin
                    stg_nxt_s = step_s.code;
                    div_nxt_s = 1'b1;
                end else begin
                    stg_nxt_s = 3'd0;
                    div_nxt_s = 1'b0;
                end
            end else if (DVST && (stg_r == 3'd0)) begin
                stg_nxt_s = STG_DV0;
                div_nxt_s = 1'b1;
            end else begin
                stg_nxt_s = {1'b0, ST2, ST1};
                div_nxt_s = 1'b0;
            end
        end else begin
            stg_nxt_s = stg_r;
            div_nxt_s = div_r;
        end
    end

    // Active-low one-hot timepulse vector from the ring position.
    always_comb begin
        t_s = '1;
        for (int i = 0; i < NTP; i++) begin
            t_s[i] = (tp_s != TPW'(i + 1));
        end
    end

    // Stage and divide decodes from the registered state.
    always_comb begin
        DV0    = div_r & (stg_r == STG_DV0);
        DV1    = div_r & (stg_r == STG_DV1);
        DV4    = div_r & (stg_r == STG_DV4);
        DV376  = div_r & ((stg_r == STG_DV3) | (stg_r == STG_DV7) | (stg_r == STG_DV6));
        DV1376 = div_r & ((stg_r == STG_DV1) | (stg_r == STG_DV3) | (stg_r == STG_DV7) |
                          (stg_r == STG_DV6));
        DV3764 = div_r & ((stg_r == STG_DV3) | (stg_r == STG_DV7) | (stg_r == STG_DV6) |
                          (stg_r == STG_DV4));
        ST0_   = ~(~div_r & (stg_r == 3'd0));
        ST1_   = ~(~div_r & (stg_r == 3'd1));
        ST3_   = ~(~div_r & (stg_r == 3'd3));
        DVDONE = div_r & (stg_r == DVLAST) & t12_s;
    end

    assign T_     = t_s;
    assign STG    = stg_r;
    assign DIVSTG = div_r;

endmodule

// File: tb/tb_stage_seq.sv
// Directed bench for stage_seq: ring, normal stages, full divide, aborts,
// monitor stop and ignored divide requests.
module tb_stage_seq;

    logic        CLOCK = 1'b0;
    logic        rst = 1'b0;
    logic        GOJAM = 1'b0;
    logic        MSTP = 1'b0;
    logic        DVST = 1'b0;
    logic        RSTSTG = 1'b0;
    logic        ST1 = 1'b0;
    logic        ST2 = 1'b0;
    logic [11:0] T_;
    logic [2:0]  STG;
    logic        DIVSTG, DV0, DV1, DV4, DV376, DV1376, DV3764;
    logic        ST0_, ST1_, ST3_, DVDONE;

    int checks = 0;
    int errors = 0;

    stage_seq dut (
        .CLOCK (CLOCK), .rst (rst), .GOJAM (GOJAM), .MSTP (MSTP),
        .DVST (DVST), .RSTSTG (RSTSTG), .ST1 (ST1), .ST2 (ST2),
        .T_ (T_), .STG (STG), .DIVSTG (DIVSTG), .DV0 (DV0), .DV1 (DV1),
        .DV4 (DV4), .DV376 (DV376), .DV1376 (DV1376), .DV3764 (DV3764),
        .ST0_ (ST0_), .ST1_ (ST1_), .ST3_ (ST3_), .DVDONE (DVDONE)
    );

    always #5 CLOCK = ~CLOCK;

    // Divide decode bundle {DIVSTG,DV0,DV1,DV4,DV376,DV1376,DV3764}.
    wire [6:0] dvv = {DIVSTG, DV0, DV1, DV4, DV376, DV1376, DV3764};
    // Non-divide decode bundle {ST0_,ST1_,ST3_}.
    wire [2:0] stv = {ST0_, ST1_, ST3_};

    task automatic clk(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset state
        clk(2);
        check("rst_T", 32'(T_), 32'hFFE);
        check("rst_stg", 32'(STG), 32'd0);
        check("rst_dv", 32'(dvv), 32'h00);
        check("rst_st", 32'(stv), 32'b011);
        check("rst_done", 32'(DVDONE), 32'd0);
        rst = 1'b1;
        check("rel_T", 32'(T_), 32'hFFE);
        clk(1);
        check("ring_T02", 32'(T_), 32'hFFD);
        clk(10);
        check("ring_T12", 32'(T_), 32'h7FF);
        clk(1);
        check("ring_wrap", 32'(T_), 32'hFFE);

        // Normal stages
        clk(11); ST1 = 1'b1; clk(1); ST1 = 1'b0;
        check("st1_stg", 32'(STG), 32'd1);
        check("st1_dec", 32'(stv), 32'b101);
        clk(11); ST1 = 1'b1; ST2 = 1'b1; clk(1); ST1 = 1'b0; ST2 = 1'b0;
        check("st3_stg", 32'(STG), 32'd3);
        check("st3_dec", 32'(stv), 32'b110);
        clk(12);
        check("st0_stg", 32'(STG), 32'd0);
        check("st0_dec", 32'(stv), 32'b011);

        // Full divide
        clk(11); DVST = 1'b1; clk(1); DVST = 1'b0;
        check("dv0_stg", 32'(STG), 32'd0);
        check("dv0_dec", 32'(dvv), 32'b1100000);
        check("dv0_st", 32'(stv), 32'b111);
        clk(11);
        check("dv0_done", 32'(DVDONE), 32'd0);
        clk(1);
        check("dv1_stg", 32'(STG), 32'd1);
        check("dv1_dec", 32'(dvv), 32'b1010010);
        clk(5); DVST = 1'b1; clk(6); clk(1); DVST = 1'b0;
        check("dv3_stg", 32'(STG), 32'd3);
        check("dv3_dec", 32'(dvv), 32'b1000111);
        clk(12);
        check("dv7_stg", 32'(STG), 32'd7);
        check("dv7_dec", 32'(dvv), 32'b1000111);
        clk(12);
        check("dv6_stg", 32'(STG), 32'd6);
        check("dv6_dec", 32'(dvv), 32'b1000111);
        clk(11); ST1 = 1'b1; clk(1); ST1 = 1'b0;
        check("dv4_stg", 32'(STG), 32'd4);
        check("dv4_dec", 32'(dvv), 32'b1001001);
        clk(10);
        check("dv4_t11_done", 32'(DVDONE), 32'd0);
        clk(1);
        check("dv4_t12_done", 32'(DVDONE), 32'd1);

        // Monitor stop stretches the last T12
        ST2 = 1'b1; MSTP = 1'b1;
        for (int i = 0; i < 20; i++) begin
            clk(1);
            check("mstp_T", 32'(T_), 32'h7FF);
            check("mstp_done", 32'(DVDONE), 32'd1);
        end
        MSTP = 1'b0; clk(1); ST2 = 1'b0;
        check("exit_T", 32'(T_), 32'hFFE);
        check("exit_stg", 32'(STG), 32'd2);
        check("exit_div", 32'(DIVSTG), 32'd0);
        check("exit_done", 32'(DVDONE), 32'd0);

        // DVST with STG=2 is ignored
        clk(11); DVST = 1'b1; ST2 = 1'b1; clk(1); DVST = 1'b0; ST2 = 1'b0;
        check("ign_stg", 32'(STG), 32'd2);
        check("ign_div", 32'(DIVSTG), 32'd0);
        clk(12);
        check("ign_back0", 32'(STG), 32'd0);

        // RSTSTG aborts at the DV7 MCT
        clk(11); DVST = 1'b1; clk(1); DVST = 1'b0;
        clk(36);
        check("ab_dv7", 32'(STG), 32'd7);
        clk(11); RSTSTG = 1'b1; clk(1); RSTSTG = 1'b0;
        check("ab_stg", 32'(STG), 32'd0);
        check("ab_div", 32'(DIVSTG), 32'd0);
        check("ab_st", 32'(stv), 32'b011);

        // GOJAM at tp=5 of DV3
        clk(11); DVST = 1'b1; clk(1); DVST = 1'b0;
        clk(24);
        check("gj_dv3", 32'(dvv), 32'b1000111);
        clk(4);
        check("gj_tp5", 32'(T_), 32'hFEF);
        GOJAM = 1'b1; clk(1); GOJAM = 1'b0;
        check("gj_T", 32'(T_), 32'hFFE);
        check("gj_stg", 32'(STG), 32'd0);
        check("gj_div", 32'(DIVSTG), 32'd0);
        clk(1);
        check("gj_T02", 32'(T_), 32'hFFD);

        // Asynchronous reset in the middle of a divide
        clk(10); DVST = 1'b1; clk(1); DVST = 1'b0;
        clk(12); clk(3);
        check("ar_pre", 32'(dvv), 32'b1010010);
        #1 rst = 1'b0;
        #1;
        check("ar_T", 32'(T_), 32'hFFE);
        check("ar_stg", 32'(STG), 32'd0);
        check("ar_dv", 32'(dvv), 32'h00);
        clk(1); rst = 1'b1;
        clk(1);
        check("ar_T02", 32'(T_), 32'hFFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_seq.md
# stage_seq

Stage-sequencing controller for the control-pulse matrix. Generates the twelve-timepulse memory-cycle ring (T01..T12). Holds the three-bit stage register STG1..STG3, which the divide/stage decode logic consumes. Steps that register through the normal instruction stages and through the six-MCT divide sequence 0→1→3→7→6→4, so that the stage-branch/divide decoders are driven from one registered source.

## Interface
Parameters:
- NTP, 12, timepulses per memory cycle time (MCT).
- DVLAST, 3'b100, stage code of the final divide MCT.

Ports:
- CLOCK  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- GOJAM  in  1  synchronous restart; clears ring and stage.
- MSTP  in  1  monitor stop; holds the ring in T12 while high.
- DVST  in  1  divide start request, sampled at T12.
- RSTSTG  in  1  stage reset request, sampled at T12.
- ST1  in  1  next MCT is stage 1, sampled at T12.
- ST2  in  1  next MCT is stage 2, sampled at T12.
- T_  out  12  active-low one-hot timepulses; bit 0 = T01_.
- STG  out  3  stage register {STG3,STG2,STG1}.
- DIVSTG  out  1  divide sequence active.
- DV0, DV1, DV4  out  1  each  divide-stage decodes.
- DV376, DV1376, DV3764  out  1  each  divide-stage group decodes.
- ST0_, ST1_, ST3_  out  1  each  active-low non-divide stage decodes.
- DVDONE  out  1  high during T12 of the last divide MCT.

## Operation
- Ring counter tp ∈ 1..NTP. T_[tp-1] is low; all other T_ bits are high.
- The ring advances by one each clock. NTP wraps to 1.
- If MSTP is high while tp = NTP, tp stays at NTP and no stage update occurs.
- Stage update happens only on the clock edge leaving T12, i.e. tp = NTP and MSTP low. Priority at that edge:
  1. GOJAM: STG = 0, DIVSTG = 0. (GOJAM also forces tp = 1 on any edge.)
  2. RSTSTG: STG = 0, DIVSTG = 0. Aborts a divide in progress.
  3. DIVSTG = 1: STG follows 0→1→3→7→6→4. From DVLAST: DIVSTG = 0, STG = {0, ST2, ST1}.
  4. DIVSTG = 0, DVST = 1, STG = 0: DIVSTG = 1, STG = 0. ST1/ST2 are ignored.
  5. Otherwise: STG = {0, ST2, ST1}.
- DVST while DIVSTG = 1, or with STG ≠ 0, is ignored and not latched.
- ST1 and ST2 both high gives STG = 3 (non-divide stage 3).
- Illegal codes while dividing (2, 5) map to stage 0 with DIVSTG cleared.
- Decodes are combinational from registers:
  - DV0 = DIVSTG & STG=0.
  - DV1 = DIVSTG & STG=1.
  - DV4 = DIVSTG & STG=4.
  - DV376 = DIVSTG & STG∈{3,7,6}.
  - DV1376 = DIVSTG & STG∈{1,3,7,6}.
  - DV3764 = DIVSTG & STG∈{3,7,6,4}.
  - ST0_ = ~(~DIVSTG & STG=0).
  - ST1_ = ~(~DIVSTG & STG=1).
  - ST3_ = ~(~DIVSTG & STG=3).
- DVDONE = DIVSTG & STG=DVLAST & tp=NTP.

## Timing
- Reset values:
  - tp = 1, so T_ = 12'hFFE.
  - STG = 0, DIVSTG = 0.
  - DV* = 0, DVDONE = 0.
  - ST0_ = 0, ST1_ = 1, ST3_ = 1.
- Reset asserted mid-divide returns to the reset state immediately, asynchronously.
- Inputs need only be valid in the T12 cycle (tp = NTP). They are don't-care in other cycles.
- Latency: a request sampled at T12 of MCT n is visible on STG from T01 of MCT n+1.
- A full divide occupies 6 MCTs: DV0, DV1, DV3, DV7, DV6, DV4. That is 72 clocks with MSTP low.
- GOJAM takes effect on the next edge regardless of tp: tp = 1, stage cleared.
- MSTP stretches T12 indefinitely. DVDONE stays high for the whole stretched T12.

## Structure
- Package agc_stage_pkg holds:
  - NTP default.
  - Stage code constants: STG_DV0=0, STG_DV1=1, STG_DV3=3, STG_DV7=7, STG_DV6=6, STG_DV4=4.
  - Next-divide-stage function.
- Sub-module tp_ring: the 1..NTP counter with MSTP hold and GOJAM clear. Outputs tp and the t12 strobe.
- stage_seq contains the stage register, divide sequencing and decode.

## Test plan
- Reset: release rst → T_ = FFE; T_ = FFD after 1 clock; T_ = 7FF after 11 clocks; wraps to FFE after 12 clocks.
- Normal stages: ST1 = 1 at T12 → STG = 1, ST1_ = 0 at next T01. ST1 = ST2 = 1 at T12 → STG = 3, ST3_ = 0.
- Full divide: DVST = 1 at T12 with STG = 0 → STG sequence 0,1,3,7,6,4 over 6 MCTs with correct DV* decodes. DVDONE high only in the final T12. Then DIVSTG = 0, STG = {0,ST2,ST1}.
- Abort: RSTSTG = 1 at T12 of the DV7 MCT → next MCT STG = 0, DIVSTG = 0. GOJAM at tp = 5 in DV3 → next clock tp = 1, STG = 0.
- MSTP: hold MSTP = 1 for 20 clocks at T12 of the DV4 MCT → T_ = 7FF and DVDONE = 1 throughout. Release → T01, DIVSTG = 0.
- Ignored DVST: DVST = 1 during DV1 and at STG = 2 → no change in sequence or stage.
